// File: rtl/csr_regfile.sv
// LoongArch control/status register file: CSR read/modify-write, exception and
// ertn commit, constant timer, interrupt pending logic and the stable counter.
module csr_regfile (
  input  logic        clk,
  input  logic        resetn,
  input  logic [79:0] csr_ctrl,
  output logic [31:0] csr_rvalue,
  input  logic        wb_ex,
  input  logic [5:0]  wb_ecode,
  input  logic [8:0]  wb_esubcode,
  input  logic [31:0] wb_pc,
  input  logic [31:0] wb_vaddr,
  input  logic        ertn_flush,
  input  logic [7:0]  hw_int,
  input  logic        ipi_int,
  output logic [31:0] ex_entry,
  output logic [31:0] ertn_entry,
  output logic        has_int,
  output logic [63:0] stable_cnt,
  output logic [31:0] tid
);

  localparam logic [13:0] CSR_CRMD   = 14'h000;
  localparam logic [13:0] CSR_PRMD   = 14'h001;
  localparam logic [13:0] CSR_ECFG   = 14'h004;
  localparam logic [13:0] CSR_ESTAT  = 14'h005;
  localparam logic [13:0] CSR_ERA    = 14'h006;
  localparam logic [13:0] CSR_BADV   = 14'h007;
  localparam logic [13:0] CSR_EENTRY = 14'h00C;
  localparam logic [13:0] CSR_SAVE0  = 14'h030;
  localparam logic [13:0] CSR_SAVE1  = 14'h031;
  localparam logic [13:0] CSR_SAVE2  = 14'h032;
  localparam logic [13:0] CSR_SAVE3  = 14'h033;
  localparam logic [13:0] CSR_TID    = 14'h040;
  localparam logic [13:0] CSR_TCFG   = 14'h041;
  localparam logic [13:0] CSR_TVAL   = 14'h042;
  localparam logic [13:0] CSR_TICLR  = 14'h044;

  localparam logic [12:0] LIE_MASK   = 13'h1BFF;

  function automatic logic [31:0] merge_wr(input logic [31:0] old_val,
                                           input logic [31:0] wdata,
                                           input logic [31:0] wmask);
    return (old_val & ~wmask) | (wdata & wmask);
  endfunction

  function automatic logic badv_ecode(input logic [5:0] ecode);
    case (ecode)
      6'h01, 6'h02, 6'h03, 6'h04, 6'h07, 6'h08, 6'h09, 6'h3F: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  logic        csr_re;
  logic        csr_we;
  logic [13:0] csr_num;
  logic [31:0] csr_wmask;
  logic [31:0] csr_wdata;

  assign {csr_re, csr_we, csr_num, csr_wmask, csr_wdata} = csr_ctrl;

  logic [1:0]  crmd_plv;
  logic        crmd_ie;
  logic        crmd_da;
  logic        crmd_pg;
  logic [1:0]  prmd_pplv;
  logic        prmd_pie;
  logic [12:0] ecfg_lie;
  logic [1:0]  is_sw;
  logic [7:0]  is_hw;
  logic        is_timer;
  logic        is_ipi;
  logic [5:0]  estat_ecode;
  logic [8:0]  estat_esubcode;
  logic [31:0] era;
  logic [31:0] badv;
  logic [25:0] eentry_va;
  logic [31:0] save [4];
  logic [31:0] tid_r;
  logic        tcfg_en;
  logic        tcfg_periodic;
  logic [29:0] tcfg_initval;
  logic [31:0] tval;
  logic [63:0] stable_cnt_r;

  logic [31:0] crmd_val;
  logic [31:0] prmd_val;
  logic [31:0] ecfg_val;
  logic [31:0] estat_val;
  logic [31:0] eentry_val;
  logic [31:0] tcfg_val;
  logic [12:0] estat_is;

  assign estat_is   = {is_ipi, is_timer, 1'b0, is_hw, is_sw};
  assign crmd_val   = {27'b0, crmd_pg, crmd_da, crmd_ie, crmd_plv};
  assign prmd_val   = {29'b0, prmd_pie, prmd_pplv};
  assign ecfg_val   = {19'b0, ecfg_lie};
  assign estat_val  = {1'b0, estat_esubcode, estat_ecode, 3'b0, estat_is};
  assign eentry_val = {eentry_va, 6'b0};
  assign tcfg_val   = {tcfg_initval, tcfg_periodic, tcfg_en};

  // An exception in the same cycle suppresses any CSR write
  logic wr_en;
  logic wr_crmd, wr_prmd, wr_ecfg, wr_estat, wr_era, wr_badv, wr_eentry;
  logic wr_save, wr_tid, wr_tcfg, wr_ticlr;

  assign wr_en     = csr_we & ~wb_ex;
  assign wr_crmd   = wr_en & (csr_num == CSR_CRMD);
  assign wr_prmd   = wr_en & (csr_num == CSR_PRMD);
  assign wr_ecfg   = wr_en & (csr_num == CSR_ECFG);
  assign wr_estat  = wr_en & (csr_num == CSR_ESTAT);
  assign wr_era    = wr_en & (csr_num == CSR_ERA);
  assign wr_badv   = wr_en & (csr_num == CSR_BADV);
  assign wr_eentry = wr_en & (csr_num == CSR_EENTRY);
  assign wr_save   = wr_en & (csr_num[13:2] == CSR_SAVE0[13:2]);
  assign wr_tid    = wr_en & (csr_num == CSR_TID);
  assign wr_tcfg   = wr_en & (csr_num == CSR_TCFG);
  assign wr_ticlr  = wr_en & (csr_num == CSR_TICLR);

  logic [31:0] crmd_new, prmd_new, ecfg_new, estat_new, era_new, badv_new;
  logic [31:0] eentry_new, save_new, tid_new, tcfg_new, ticlr_new;

  assign crmd_new   = merge_wr(crmd_val, csr_wdata, csr_wmask);
  assign prmd_new   = merge_wr(prmd_val, csr_wdata, csr_wmask);
  assign ecfg_new   = merge_wr(ecfg_val, csr_wdata, csr_wmask);
  assign estat_new  = merge_wr(estat_val, csr_wdata, csr_wmask);
  assign era_new    = merge_wr(era, csr_wdata, csr_wmask);
  assign badv_new   = merge_wr(badv, csr_wdata, csr_wmask);
  assign eentry_new = merge_wr(eentry_val, csr_wdata, csr_wmask);
  assign save_new   = merge_wr(save[csr_num[1:0]], csr_wdata, csr_wmask);
  assign tid_new    = merge_wr(tid_r, csr_wdata, csr_wmask);
  assign tcfg_new   = merge_wr(tcfg_val, csr_wdata, csr_wmask);
  assign ticlr_new  = merge_wr(32'b0, csr_wdata, csr_wmask);

  // Timer fires on the edge that observes TVAL=0; a TCFG reload preempts it
  logic timer_fire;
  assign timer_fire = ~wr_tcfg & tcfg_en & (tval == 32'h0);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      crmd_plv       <= 2'b0;
      crmd_ie        <= 1'b0;
      crmd_da        <= 1'b1;
      crmd_pg        <= 1'b0;
      prmd_pplv      <= 2'b0;
      prmd_pie       <= 1'b0;
      ecfg_lie       <= 13'b0;
      is_sw          <= 2'b0;
      is_hw          <= 8'b0;
      is_timer       <= 1'b0;
      is_ipi         <= 1'b0;
      estat_ecode    <= 6'b0;
      estat_esubcode <= 9'b0;
      era            <= 32'b0;
      badv           <= 32'b0;
      eentry_va      <= 26'b0;
      for (int i = 0; i < 4; i++) save[i] <= 32'b0;
      tid_r          <= 32'b0;
      tcfg_en        <= 1'b0;
      tcfg_periodic  <= 1'b0;
      tcfg_initval   <= 30'b0;
      tval           <= 32'hFFFF_FFFF;
      stable_cnt_r   <= 64'b0;
    end else begin
      if (wb_ex) begin
        crmd_plv <= 2'b0;
        crmd_ie  <= 1'b0;
      end else if (ertn_flush) begin
        crmd_plv <= prmd_pplv;
        crmd_ie  <= prmd_pie;
      end else if (wr_crmd) begin
        crmd_plv <= crmd_new[1:0];
        crmd_ie  <= crmd_new[2];
      end
      if (wr_crmd) begin
        crmd_da <= crmd_new[3];
        crmd_pg <= crmd_new[4];
      end

      if (wb_ex) begin
        prmd_pplv <= crmd_plv;
        prmd_pie  <= crmd_ie;
      end else if (wr_prmd) begin
        prmd_pplv <= prmd_new[1:0];
        prmd_pie  <= prmd_new[2];
      end

      if (wr_ecfg) ecfg_lie <= ecfg_new[12:0] & LIE_MASK;

      if (wr_estat) is_sw <= estat_new[1:0];
      is_hw  <= hw_int;
      is_ipi <= ipi_int;
      if (timer_fire) is_timer <= 1'b1;
      else if (wr_ticlr && ticlr_new[0]) is_timer <= 1'b0;

      if (wb_ex) begin
        estat_ecode    <= wb_ecode;
        estat_esubcode <= wb_esubcode;
      end

      if (wb_ex) era <= wb_pc;
      else if (wr_era) era <= era_new;

      if (wb_ex && badv_ecode(wb_ecode)) badv <= wb_vaddr;
      else if (wr_badv) badv <= badv_new;

      if (wr_eentry) eentry_va <= eentry_new[31:6];
      if (wr_save) save[csr_num[1:0]] <= save_new;
      if (wr_tid) tid_r <= tid_new;

      if (wr_tcfg) begin
        tcfg_en       <= tcfg_new[0];
        tcfg_periodic <= tcfg_new[1];
        tcfg_initval  <= tcfg_new[31:2];
      end

      if (wr_tcfg) begin
        tval <= {tcfg_new[31:2], 2'b00};
      end else if (tcfg_en && tval != 32'hFFFF_FFFF) begin
        if (tval == 32'h0) tval <= tcfg_periodic ? {tcfg_initval, 2'b00} : 32'hFFFF_FFFF;
        else tval <= tval - 32'd1;
      end

      stable_cnt_r <= stable_cnt_r + 64'd1;
    end
  end

  always_comb begin
    csr_rvalue = 32'b0;
    if (csr_re) begin
      case (csr_num)
        CSR_CRMD:   csr_rvalue = crmd_val;
        CSR_PRMD:   csr_rvalue = prmd_val;
        CSR_ECFG:   csr_rvalue = ecfg_val;
        CSR_ESTAT:  csr_rvalue = estat_val;
        CSR_ERA:    csr_rvalue = era;
        CSR_BADV:   csr_rvalue = badv;
        CSR_EENTRY: csr_rvalue = eentry_val;
        CSR_SAVE0:  csr_rvalue = save[0];
        CSR_SAVE1:  csr_rvalue = save[1];
        CSR_SAVE2:  csr_rvalue = save[2];
        CSR_SAVE3:  csr_rvalue = save[3];
        CSR_TID:    csr_rvalue = tid_r;
        CSR_TCFG:   csr_rvalue = tcfg_val;
        CSR_TVAL:   csr_rvalue = tval;
        default:    csr_rvalue = 32'b0;
      endcase
    end
  end

  assign ex_entry   = eentry_val;
  assign ertn_entry = era;
  assign has_int    = crmd_ie & |(estat_is & ecfg_lie);
  assign stable_cnt = stable_cnt_r;
  assign tid        = tid_r;

endmodule
